i2s_pwm_dac: RTL
================

I2S_PWM_DAC -- requirements
Module: i2s_pwm_dac

Interface
REQ-001 SHALL have parameter DATA_W, default 16, captured sample width in bits (range 8..32).
REQ-002 SHALL have parameter PWM_W, default 8, PWM resolution in bits (range 4..DATA_W).
REQ-003 SHALL have parameter JUSTIFY, default 0: 0 = I2S (MSB one bit_clk after lr_clk edge), 1 = left-justified (MSB on first bit_clk after edge).
REQ-004 SHALL have parameter TO_W, default 12, link-timeout counter width.
REQ-005 Port: clk  input  1  system clock; all logic on rising edge.
REQ-006 Port: rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: bit_clk  input  1  I2S serial clock, asynchronous to clk.
REQ-008 Port: lr_clk  input  1  word select; 0 = left, 1 = right; asynchronous.
REQ-009 Port: sdin  input  1  serial data, MSB first, two's complement; asynchronous.
REQ-010 Port: left_pwm  output  1  left-channel PWM.
REQ-011 Port: right_pwm  output  1  right-channel PWM.
REQ-012 Port: frame_valid  output  1  one-clk pulse when a right-channel sample is latched.
REQ-013 Port: link_ok  output  1  high while bit_clk activity is present.

Function
REQ-014 bit_clk, lr_clk, sdin SHALL each pass through a 2-flop synchronizer; bit_clk rising edge detected from synchronized value; clk frequency SHALL be at least 4x bit_clk frequency.
REQ-015 On each bit_clk rise: sample sdin and lr_clk; lr_clk differing from previous sampled value marks slot end for the previous channel and start of a new slot.
REQ-016 Bit index within slot: JUSTIFY=0 discards the first bit after the edge; JUSTIFY=1 takes it as MSB.
REQ-017 First DATA_W data bits of a slot SHALL shift in MSB-first; further bits discarded; if slot ends early, unreceived LSBs SHALL be zero.
REQ-018 At slot end, shift register SHALL be copied to the channel's holding register (lr previous 0 -> left, 1 -> right); right copy pulses frame_valid for exactly one clk.
REQ-019 PWM counter SHALL be PWM_W bits, free-running on clk, wrapping 2^PWM_W-1 -> 0.
REQ-020 Duty = top PWM_W bits of holding register with MSB inverted (two's complement -> offset binary).
REQ-021 Duty registers SHALL load from holding registers only on the clk where counter = 0 (glitch-free period boundary).
REQ-022 Output SHALL be high when counter < duty: duty 0 -> constantly low; duty 2^PWM_W-1 -> high all but one cycle per period.
REQ-023 Timeout counter SHALL reset on every bit_clk rise and saturate at 2^TO_W-1; at saturation link_ok = 0 and both holding registers forced to zero (midscale duty).
REQ-024 link_ok SHALL rise on the first bit_clk rise after timeout; first partial slot after recovery SHALL be discarded.
REQ-025 Simultaneous slot end and counter = 0: duty load SHALL use the pre-update holding value; the new sample takes effect next period.

Reset
REQ-026 While rst_n = 0: left_pwm, right_pwm, frame_valid, link_ok = 0; synchronizers, shift register, bit index, PWM and timeout counters = 0; holding and duty registers = midscale (holding 0, duty 2^(PWM_W-1)).
REQ-027 After release, PWM SHALL run at 50% duty until the first complete samples load; first slot after reset SHALL be discarded.
REQ-028 Reset assertion mid-slot SHALL abandon the partial sample with no frame_valid pulse.

Configuration
REQ-029 Macro I2S_PWM_ATTEN_EN defined: add port atten  input  3  attenuation; holding value arithmetic-right-shifted by atten (sign-extended) before duty conversion, sampled at counter = 0.
REQ-030 Macro I2S_PWM_ATTEN_EN undefined: no atten port; duty derived unshifted; behaviour identical to atten = 0.

Verification
REQ-031 Defaults, I2S frame left 0x7FFF, right 0x8000 -> after next counter wrap left_pwm high 255 of 256 clks, right_pwm constantly low; one frame_valid pulse per frame.
REQ-032 Left 0x0000, right 0x4000 -> left high 128/256 clks, right high 192/256 clks.
REQ-033 JUSTIFY=1, 24-bit slots carrying 0xC00000 -> left duty 0x40 (64/256 clks); extra 8 bits ignored.
REQ-034 Stop bit_clk for 4096 clks -> link_ok falls, both outputs 50%; restart -> link_ok rises on first bit_clk rise, valid duty after one full frame.
REQ-035 rst_n pulsed low mid-left-slot -> all outputs 0 during reset, no frame_valid, 50% duty after release until the next complete frame.
REQ-036 With I2S_PWM_ATTEN_EN, atten = 2, sample 0x7FFF -> duty 0x9F (high 159/256 clks).

Source files
------------

// File: rtl/i2s_pwm_dac.sv
// I2S / left-justified serial receiver feeding a two-channel PWM DAC, falling back to midscale on link loss.
// Optional attenuation input is enabled by defining I2S_PWM_ATTEN_EN.
module i2s_pwm_dac #(
    parameter int DATA_W  = 16,
    parameter int PWM_W   = 8,
    parameter int JUSTIFY = 0,
    parameter int TO_W    = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_clk,
    input  logic       lr_clk,
    input  logic       sdin,
`ifdef I2S_PWM_ATTEN_EN
    input  logic [2:0] atten,
`endif
    output logic       left_pwm,
    output logic       right_pwm,
    output logic       frame_valid,
    output logic       link_ok
);
    localparam int IDX_W = $clog2(DATA_W + 2) + 1;
    localparam int OFF   = (JUSTIFY == 0) ? 1 : 0;
    localparam logic [DATA_W-1:0] MSB_BIT = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [PWM_W-1:0]  MID     = {1'b1, {(PWM_W-1){1'b0}}};

    function automatic logic [PWM_W-1:0] to_duty(input logic signed [DATA_W-1:0] s,
                                                 input logic [2:0] sh);
        logic signed [DATA_W-1:0] a;
        logic [DATA_W-1:0]        ob;
        a  = s >>> sh;
        ob = {~a[DATA_W-1], a[DATA_W-2:0]};
        return PWM_W'(ob >> (DATA_W - PWM_W));
    endfunction

    logic bclk_p0, bclk_p1, bclk_p2, lr_p0, lr_p1, sd_p0, sd_p1;
    logic bclk_rise;

    // Stage p0/p1: synchronizers, p2: bit_clk edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_p0 <= 1'b0; bclk_p1 <= 1'b0; bclk_p2 <= 1'b0;
            lr_p0   <= 1'b0; lr_p1   <= 1'b0;
            sd_p0   <= 1'b0; sd_p1   <= 1'b0;
        end else begin
            bclk_p0 <= bit_clk; bclk_p1 <= bclk_p0; bclk_p2 <= bclk_p1;
            lr_p0   <= lr_clk;  lr_p1   <= lr_p0;
            sd_p0   <= sdin;    sd_p1   <= sd_p0;
        end
    end

    assign bclk_rise = bclk_p1 & ~bclk_p2;

    logic [IDX_W-1:0]         bit_idx, cur_idx, data_pos;
    logic [DATA_W-1:0]        bit_mask, shift_sr;
    logic signed [DATA_W-1:0] hold_l, hold_r;
    logic                     lr_prev, primed, slot_ok, slot_edge;
    logic [TO_W-1:0]          to_cnt;
    logic                     to_sat;

    // The first bit of a slot has index 0; in I2S mode it maps past the register and is dropped.
    assign slot_edge = primed && (lr_p1 != lr_prev);
    assign cur_idx   = slot_edge ? '0 : bit_idx;
    assign data_pos  = cur_idx - IDX_W'(OFF);
    assign bit_mask  = sd_p1 ? (MSB_BIT >> data_pos) : '0;
    assign to_sat    = &to_cnt;

    // Receive stage: slot tracking, holding registers, link supervision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx     <= '0;
            shift_sr    <= '0;
            hold_l      <= '0;
            hold_r      <= '0;
            lr_prev     <= 1'b0;
            primed      <= 1'b0;
            slot_ok     <= 1'b0;
            to_cnt      <= '0;
            link_ok     <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (bclk_rise) begin
                to_cnt  <= '0;
                link_ok <= 1'b1;
                if (!primed) begin
                    primed  <= 1'b1;
                    lr_prev <= lr_p1;
                    slot_ok <= 1'b0;
                end else if (slot_edge) begin
                    if (slot_ok) begin
                        if (lr_prev) begin
                            hold_r      <= $signed(shift_sr);
                            frame_valid <= 1'b1;
                        end else begin
                            hold_l <= $signed(shift_sr);
                        end
                    end
                    slot_ok  <= 1'b1;
                    lr_prev  <= lr_p1;
                    shift_sr <= bit_mask;
                    bit_idx  <= IDX_W'(1);
                end else begin
                    shift_sr <= shift_sr | bit_mask;
                    if (!(&bit_idx))
                        bit_idx <= bit_idx + IDX_W'(1);
                end
            end else if (to_sat) begin
                link_ok <= 1'b0;
                primed  <= 1'b0;
                slot_ok <= 1'b0;
                hold_l  <= '0;
                hold_r  <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    logic [PWM_W-1:0] cnt_p0, cnt_p1, duty_l, duty_r;
    logic [2:0]       atten_s;

`ifdef I2S_PWM_ATTEN_EN
    assign atten_s = atten;
`else
    assign atten_s = 3'd0;
`endif

    // PWM stage p0: counter and period-boundary duty load, p1: compare into registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0    <= '0;
            cnt_p1    <= '0;
            duty_l    <= MID;
            duty_r    <= MID;
            left_pwm  <= 1'b0;
            right_pwm <= 1'b0;
        end else begin
            cnt_p0 <= cnt_p0 + PWM_W'(1);
            cnt_p1 <= cnt_p0;
            if (cnt_p0 == '0) begin
                duty_l <= to_duty(hold_l, atten_s);
                duty_r <= to_duty(hold_r, atten_s);
            end
            left_pwm  <= (cnt_p1 < duty_l);
            right_pwm <= (cnt_p1 < duty_r);
        end
    end

endmodule
